// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared types and constants for the user-project UART blocks.
//   rx_state_t   : receive FSM state encoding
//   UART_*       : frame format, divider floor and nominal system clock
//   uart_maj3    : 2-of-3 majority vote used by the pad input filters
package uart_pkg;

   localparam int UART_DATA_BITS   = 8;
   localparam int UART_MIN_CLK_DIV = 4;
   localparam int UART_SYS_CLK_HZ  = 40000000;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK
   } rx_state_t;

   function automatic logic uart_maj3(input logic [2:0] v);
      return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync
//   Conditions one asynchronous pad input: 2-flop synchroniser, 3-sample
//   history of the synchronised level and a majority-voted sample.
//   wb_clk_i : system clock
//   wb_rst_i : synchronous active-high reset (line parks at idle-high)
//   din      : raw asynchronous pad input
//   sync     : synchronised level
//   fall     : one-cycle strobe on a synchronised high-to-low transition
//   maj      : majority of the last three synchronised samples
module uart_rx_sync
   import uart_pkg::*;
(
   input  logic wb_clk_i,
   input  logic wb_rst_i,
   input  logic din,
   output logic sync,
   output logic fall,
   output logic maj
);

   logic       meta;
   logic [2:0] hist;

   // Everything resets to the idle-high line level so reset never looks like
   // a start edge.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         meta <= 1'b1;
         sync <= 1'b1;
         hist <= 3'b111;
      end else begin
         meta <= din;
         sync <= meta;
         hist <= {hist[1:0], sync};
      end
   end

   // hist[0] is the newest sample, hist[1] the one before it.
   assign fall = hist[1] & ~hist[0];
   assign maj  = uart_maj3(hist);

endmodule

// File: rtl/uart_rx_oversampler.sv
// uart_rx_oversampler
//   UART 8N1 receive front end. Detects and qualifies start bits, samples
//   each bit at its centre with a 3-sample majority vote and pushes one byte
//   per good frame into the RX FIFO.
//   wb_clk_i  : system clock (single domain)
//   wb_rst_i  : synchronous active-high reset
//   clk_div   : clocks per bit, captured when a start edge is seen
//   rx        : raw asynchronous pad input, idle high
//   rx_data   : last received byte, held until the next frame completes
//   rx_valid  : one-cycle pulse for a good frame (FIFO push)
//   frame_err : one-cycle pulse when the stop bit samples low
//   busy      : high whenever the receiver is not idle
module uart_rx_oversampler
   import uart_pkg::*;
#(
   parameter int DATA_BITS   = UART_DATA_BITS,
   parameter int MIN_CLK_DIV = UART_MIN_CLK_DIV
) (
   input  logic                 wb_clk_i,
   input  logic                 wb_rst_i,
   input  logic [31:0]          clk_div,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 frame_err,
   output logic                 busy
);

   localparam logic [31:0] MIN_DIV  = 32'(MIN_CLK_DIV);
   localparam logic [2:0]  LAST_BIT = 3'(DATA_BITS - 1);

   rx_state_t            state;
   logic [31:0]          div;
   logic [31:0]          cnt;
   logic [2:0]           bit_idx;
   logic [DATA_BITS-1:0] shreg;

   logic                 rx_sync;
   logic                 rx_fall;
   logic                 rx_maj;
   logic [31:0]          div_eff;
   logic [31:0]          half;
   logic [31:0]          div_m1;

   uart_rx_sync u_sync (
      .wb_clk_i (wb_clk_i),
      .wb_rst_i (wb_rst_i),
      .din      (rx),
      .sync     (rx_sync),
      .fall     (rx_fall),
      .maj      (rx_maj)
   );

   assign div_eff = (clk_div < MIN_DIV) ? MIN_DIV : clk_div;
   assign half    = div >> 1;
   assign div_m1  = div - 32'd1;

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state     <= IDLE;
         div       <= MIN_DIV;
         cnt       <= '0;
         bit_idx   <= '0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         busy      <= 1'b0;
      end else begin
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         // Saturating count: a stuck state can never alias back to a match.
         if (cnt != '1)
            cnt <= cnt + 32'd1;

         case (state)
            IDLE: begin
               busy <= 1'b0;
               if (rx_fall) begin
                  state <= START;
                  cnt   <= '0;
                  div   <= div_eff;
                  busy  <= 1'b1;
               end
            end

            START: begin
               // Half a bit in: still low means a real start bit.
               if (cnt == half) begin
                  if (!rx_maj) begin
                     state   <= DATA;
                     cnt     <= '0;
                     bit_idx <= '0;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end
            end

            DATA: begin
               if (cnt == div_m1) begin
                  shreg[bit_idx] <= rx_maj;
                  cnt            <= '0;
                  bit_idx        <= bit_idx + 3'd1;
                  if (bit_idx == LAST_BIT)
                     state <= STOP;
               end
            end

            STOP: begin
               // Leaving at mid stop bit gives the next start edge half a
               // bit of margin.
               if (cnt == div_m1) begin
                  rx_data <= shreg;
                  if (rx_maj) begin
                     rx_valid <= 1'b1;
                     state    <= IDLE;
                     busy     <= 1'b0;
                  end else begin
                     frame_err <= 1'b1;
                     state     <= BREAK;
                  end
               end
            end

            BREAK: begin
               // Hold off until the line returns high so a held-low line
               // cannot produce a stream of bogus frames.
               if (rx_sync) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end

            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/uart_rx_oversampler.md
# uart_rx_oversampler

Serial-to-parallel front end for the user-project UART receive path: synchronises the raw `rx` pad input, detects and qualifies start bits, samples 8N1 frames at bit centres using 3-sample majority voting, and emits one byte per frame as a single-cycle push into the RX FIFO. It sits between the `mprj_io` RX pad and the RX FIFO. It is clocked from the Wishbone clock, and its bit period comes from the same `clk_div` value the transmitter uses.

## Interface
Parameters:
- `DATA_BITS`, 8, data bits per frame. Only 8 is supported; the parameter exists for the package constant.
- `MIN_CLK_DIV`, 4, floor applied to `clk_div`.

Ports:
- `wb_clk_i`  in  1  system clock. Single clock domain.
- `wb_rst_i`  in  1  reset, synchronous, active-high.
- `clk_div`  in  32  clocks per bit, sampled only in IDLE. Values below `MIN_CLK_DIV` are treated as `MIN_CLK_DIV`.
- `rx`  in  1  raw asynchronous pad input. Idle level is high.
- `rx_data`  out  8  last received byte, LSB first on the wire. Held until the next frame completes.
- `rx_valid`  out  1  one-cycle pulse when a good frame completes. Drives FIFO `push`.
- `frame_err`  out  1  one-cycle pulse when the stop bit samples low.
- `busy`  out  1  high in every state except IDLE.

## Operation
- **Input conditioning.** `rx` passes through a 2-flop synchroniser (both flops reset to 1). It then feeds a 3-bit history shift register (`hist`, reset to 3'b111). The sampled bit value is `maj = majority(hist)`.
- **Bit period.** `div` is latched on entry to START as `max(clk_div, MIN_CLK_DIV)`. `half = div >> 1`. The counter `cnt` is 32 bits and increments with no wrap until it is cleared.
- **States:**
  - **IDLE:** `busy = 0`. A synchronised falling edge (previous sync = 1, current = 0) moves to START, with `cnt = 0` and `div` latched.
  - **START:** at `cnt == half`, if `maj == 0`, go to DATA with `cnt = 0` and `bit_idx = 0`. If `maj == 1`, the event is a glitch: return to IDLE with no output.
  - **DATA:** at `cnt == div - 1`, shift `maj` into bit `bit_idx` of the shift register, set `cnt = 0` and increment `bit_idx`. After bit 7, go to STOP.
  - **STOP:** at `cnt == div - 1`:
    - If `maj == 1`: load `rx_data`, pulse `rx_valid`, go to IDLE.
    - If `maj == 0`: load `rx_data`, pulse `frame_err` (no `rx_valid`), go to BREAK.
  - **BREAK:** wait until the synchronised `rx == 1`, then go to IDLE. This prevents a held-low line from generating repeated frames.
- **Majority window.** `hist` holds the samples from the three cycles ending at each sample point. The sample point falls at the centre of each bit; no extra latency is added.
- **Output exclusivity.** `rx_valid` and `frame_err` are never high in the same cycle.
- **Back-to-back frames.** IDLE is re-entered at the centre of the stop bit. A new start edge arriving half a bit later is therefore captured; there is no dead time.
- **Reset mid-frame.** All state returns to IDLE. Outputs become: `rx_data = 0`, `rx_valid = 0`, `frame_err = 0`, `busy = 0`. A partial frame is discarded.
- **`clk_div` change mid-frame.** Ignored until the next IDLE→START transition.

## Timing
- **Reset values:** `rx_data` 8'h00, `rx_valid` 0, `frame_err` 0, `busy` 0, state IDLE.
- **Edge detection.** A pad falling edge at cycle t is detected at t+2 (synchroniser). START is entered and `busy` rises at t+3.
- **Data sampling.** Bit k (k = 0..7) is sampled at cycle (START entry) + `half` + 1 + (k+1)·`div`.
- **Completion.** The stop bit is sampled at (START entry) + `half` + 1 + 9·`div`. `rx_valid` or `frame_err` is high in the following cycle, together with the new `rx_data` and `busy = 0`.
- **Per-frame latency.** Start edge to `rx_valid` is approximately 9.5·`div` + 4 cycles.

## Structure
- **Shared package `uart_pkg`:**
  - state enum `rx_state_t` (IDLE, START, DATA, STOP, BREAK);
  - `UART_DATA_BITS = 8`;
  - `UART_MIN_CLK_DIV = 4`;
  - `UART_SYS_CLK_HZ = 40000000`.
- **Sub-module `uart_rx_sync`:** 2-flop synchroniser plus 3-bit history register plus majority output. It is reused by any future pad input.
- The FSM, counters and shift register stay in the top block.

## Test plan
- **Good frame.** `clk_div = 16`; drive 0x5A as 8N1 → exactly one `rx_valid` pulse, `rx_data = 8'h5A`, `frame_err` stays 0, `busy` low one cycle after.
- **Glitch rejection.** `clk_div = 16`; pulse `rx` low for 4 cycles → returns to IDLE from START, no `rx_valid`, no `frame_err`, `busy` high for ≤ 9 cycles.
- **Framing error / break.** Drive 0xA5 with the stop bit low, hold `rx` low for 40 cycles, then release → `rx_data = 8'hA5`, one `frame_err` pulse, no `rx_valid`. `busy` stays high until `rx` is high again, and no second frame is produced.
- **Noise immunity.** In each data bit of 0x3C, invert `rx` for 1 cycle exactly at the bit centre → `rx_data = 8'h3C` (majority vote).
- **Back-to-back and divider.** `clk_div = 4166`; send 0x00, 0xFF, 0x81 with no idle gap → three `rx_valid` pulses, data in order. Repeat with `clk_div = 2` → behaves as `div = 4`.
- **Reset mid-frame.** Assert `wb_rst_i` for 1 cycle during bit 3 of a frame → all outputs at reset values next cycle, no pulse for the partial frame. A following frame 0x11 is received correctly.
